// File: rtl/tile_byte_streamer_if.sv
// Tile-in / byte-out handshake bundle for tile_byte_streamer.
// master: upstream tile source plus downstream byte sink (the environment).
// slave : the streamer itself.
interface tile_byte_streamer_if #(
   parameter int unsigned TILE_BYTES = 16,
   parameter int unsigned TAG_W      = 8
);
   // Tile side
   logic                    tile_valid;
   logic                    tile_ready;
   logic [TILE_BYTES*8-1:0] tile_data;
   logic [TAG_W-1:0]        tile_tag;

   // Byte side
   logic                    byte_ready;
   logic                    data_valid;
   logic [7:0]              data_out;
   logic                    data_last;
   logic [TAG_W-1:0]        data_tag;

   modport master (
      output tile_valid, tile_data, tile_tag, byte_ready,
      input  tile_ready, data_valid, data_out, data_last, data_tag
   );

   modport slave (
      input  tile_valid, tile_data, tile_tag, byte_ready,
      output tile_ready, data_valid, data_out, data_last, data_tag
   );
endinterface

// File: rtl/tile_byte_streamer.sv
// tile_byte_streamer: buffers whole tiles in a small circular FIFO and emits
// them one byte per cycle (byte 0 first), flagging the last byte of each tile.
// Optional reference CRC-16-CCITT over each tile is built when the macro
// TILE_STREAM_CRC_EN is defined; otherwise expected_crc/expected_crc_valid
// are tied to zero.
module tile_byte_streamer #(
   parameter int unsigned TILE_BYTES = 16,
   parameter int unsigned FIFO_DEPTH = 2,
   parameter int unsigned TAG_W      = 8
) (
   input  logic                             clk,
   input  logic                             rst_n,
   tile_byte_streamer_if.slave              bus,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_level,
   output logic                             busy,
   output logic [15:0]                      expected_crc,
   output logic                             expected_crc_valid
);

   localparam int unsigned DATA_W = TILE_BYTES * 8;
   localparam int unsigned LVL_W  = $clog2(FIFO_DEPTH + 1);
   localparam int unsigned PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned CNT_W  = $clog2(TILE_BYTES);

   localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(TILE_BYTES - 1);
   localparam logic [LVL_W-1:0] DEPTH_LVL = LVL_W'(FIFO_DEPTH);
   localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(FIFO_DEPTH - 1);

   localparam logic [0:0] ST_IDLE   = 1'b0;
   localparam logic [0:0] ST_STREAM = 1'b1;

   // Tile storage
   logic [DATA_W-1:0] mem_data [FIFO_DEPTH];
   logic [TAG_W-1:0]  mem_tag  [FIFO_DEPTH];

   logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q, rd_ptr_d;
   logic [LVL_W-1:0]  level_q, level_d;

   logic [0:0]        state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;

   logic              valid_q, valid_d;
   logic [7:0]        out_q, out_d;
   logic              last_q, last_d;
   logic [TAG_W-1:0]  tag_q, tag_d;

   logic              tile_ready_c;
   logic              push_c;
   logic              xfer_c;
   logic              pop_c;
   logic              bypass_c;
   logic [DATA_W-1:0] head_data;
   logic [TAG_W-1:0]  head_tag;

   // Select byte k of a tile; byte 0 sits in the most significant lane
   function automatic logic [7:0] pick_byte(input logic [DATA_W-1:0] d,
                                            input logic [CNT_W-1:0]  k);
      logic [7:0] b;
      b = '0;
      for (int unsigned i = 0; i < TILE_BYTES; i++) begin
         if (k == CNT_W'(i)) b = d[(TILE_BYTES-1-i)*8 +: 8];
      end
      return b;
   endfunction

   // Circular pointer advance wrapping at FIFO_DEPTH
   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
      return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
   endfunction

   // Handshake decode from registered state
   assign tile_ready_c = (level_q < DEPTH_LVL);
   assign push_c       = rst_n && bus.tile_valid && tile_ready_c;
   assign xfer_c       = valid_q && bus.byte_ready;
   assign pop_c        = xfer_c && (cnt_q == LAST_CNT);
   assign cnt_inc      = cnt_q + CNT_W'(1);
   assign rd_ptr_d     = pop_c ? next_ptr(rd_ptr_q) : rd_ptr_q;

   // A tile arriving into an otherwise-drained FIFO is not yet in storage
   assign bypass_c     = push_c && (level_q == LVL_W'(pop_c));

   // Head entry that the next presented byte is taken from
   always_comb begin
      head_data = mem_data[rd_ptr_d];
      head_tag  = mem_tag[rd_ptr_d];
      if (bypass_c) begin
         head_data = bus.tile_data;
         head_tag  = bus.tile_tag;
      end
   end

   // Occupancy update: simultaneous push and pop leaves the level unchanged
   always_comb begin
      level_d = level_q;
      if (push_c && !pop_c)      level_d = level_q + LVL_W'(1);
      else if (!push_c && pop_c) level_d = level_q - LVL_W'(1);
   end

   // Next-state and next-output decode for the byte streaming FSM
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      valid_d = valid_q;
      out_d   = out_q;
      last_d  = last_q;
      tag_d   = tag_q;
      case (state_q)
         ST_IDLE: begin
            if (level_q != '0) begin
               state_d = ST_STREAM;
               cnt_d   = '0;
               valid_d = 1'b1;
               out_d   = pick_byte(head_data, '0);
               last_d  = 1'b0;
               tag_d   = head_tag;
            end
         end
         ST_STREAM: begin
            if (xfer_c) begin
               if (pop_c) begin
                  cnt_d = '0;
                  if (level_d != '0) begin
                     valid_d = 1'b1;
                     out_d   = pick_byte(head_data, '0);
                     last_d  = 1'b0;
                     tag_d   = head_tag;
                  end else begin
                     state_d = ST_IDLE;
                     valid_d = 1'b0;
                     out_d   = '0;
                     last_d  = 1'b0;
                     tag_d   = '0;
                  end
               end else begin
                  cnt_d  = cnt_inc;
                  out_d  = pick_byte(head_data, cnt_inc);
                  last_d = (cnt_inc == LAST_CNT);
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            valid_d = 1'b0;
            out_d   = '0;
            last_d  = 1'b0;
            tag_d   = '0;
         end
      endcase
   end

   // FSM state, byte counter and registered byte-side outputs
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         valid_q <= 1'b0;
         out_q   <= '0;
         last_q  <= 1'b0;
         tag_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         valid_q <= valid_d;
         out_q   <= out_d;
         last_q  <= last_d;
         tag_q   <= tag_d;
      end
   end

   // FIFO pointers and occupancy; reset flushes any queued or partial tile
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         if (push_c) wr_ptr_q <= next_ptr(wr_ptr_q);
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
      end
   end

   // Tile payload storage, no reset needed
   always_ff @(posedge clk) begin
      if (push_c) begin
         mem_data[wr_ptr_q] <= bus.tile_data;
         mem_tag[wr_ptr_q]  <= bus.tile_tag;
      end
   end

`ifdef TILE_STREAM_CRC_EN
   logic [15:0] crc_q;
   logic [15:0] crc_next_c;

   // CRC-16-CCITT (poly 0x1021), one byte, MSB first
   function automatic logic [15:0] crc16_byte(input logic [15:0] c,
                                              input logic [7:0]  b);
      logic [15:0] r;
      r = c ^ {b, 8'h00};
      for (int i = 0; i < 8; i++) begin
         r = r[15] ? ((r << 1) ^ 16'h1021) : (r << 1);
      end
      return r;
   endfunction

   assign crc_next_c = crc16_byte(crc_q, out_q);

   // Running CRC per tile; final value published the cycle after the last byte
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         crc_q              <= 16'hFFFF;
         expected_crc       <= 16'h0000;
         expected_crc_valid <= 1'b0;
      end else begin
         expected_crc_valid <= pop_c;
         if (xfer_c) begin
            if (pop_c) begin
               crc_q        <= 16'hFFFF;
               expected_crc <= crc_next_c;
            end else begin
               crc_q <= crc_next_c;
            end
         end
      end
   end
`else
   assign expected_crc       = 16'h0000;
   assign expected_crc_valid = 1'b0;
`endif

   // Port drive
   assign bus.tile_ready = tile_ready_c;
   assign bus.data_valid = valid_q;
   assign bus.data_out   = out_q;
   assign bus.data_last  = last_q;
   assign bus.data_tag   = tag_q;
   assign fifo_level     = level_q;
   assign busy           = (level_q != '0);

endmodule

// File: doc/tile_byte_streamer.md
# tile_byte_streamer

Serializes whole tiles into the byte stream that feeds the tile hash generator. Accepts one `TILE_BYTES`-byte tile per valid/ready handshake and buffers up to `FIFO_DEPTH` tiles. Emits the tiles one byte per cycle, byte 0 first, and marks the final byte of each tile. Sits between the tile fetch path and the CRC-16 hash generator; it can optionally produce its own reference CRC for self-checking.

## Interface
- `TILE_BYTES`, 16: bytes per tile; legal range is 2 or more.
- `FIFO_DEPTH`, 2: number of tiles buffered; legal range is 1 or more, any integer.
- `TAG_W`, 8: width of the tile tag carried alongside each tile.
- `clk`  in  1  sole clock; all logic is on the rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `tile_valid`  in  1  upstream tile offered.
- `tile_ready`  out  1  a tile can be accepted this cycle.
- `tile_data`  in  `TILE_BYTES*8`  tile payload; byte k = `tile_data[(TILE_BYTES-1-k)*8 +: 8]`.
- `tile_tag`  in  `TAG_W`  opaque ID travelling with the tile.
- `byte_ready`  in  1  downstream accepts a byte; tie high when driving the hash generator.
- `data_valid`  out  1  byte on `data_out` is valid.
- `data_out`  out  8  current byte.
- `data_last`  out  1  current byte is byte `TILE_BYTES-1`.
- `data_tag`  out  `TAG_W`  tag of the tile being streamed.
- `fifo_level`  out  `$clog2(FIFO_DEPTH+1)`  number of tiles held, including the one streaming.
- `busy`  out  1  `fifo_level != 0`.
- `expected_crc`  out  16  reference CRC; see Configuration.
- `expected_crc_valid`  out  1  one-cycle pulse marking `expected_crc`.

## Operation
- **Input side**
  - Push occurs when `tile_valid && tile_ready`.
  - `tile_ready = (fifo_level < FIFO_DEPTH)`, computed from the registered level only.
  - A pop in the same cycle never enables a push into a full FIFO.
  - Storage is a circular buffer of {data, tag} with write and read pointers that wrap at `FIFO_DEPTH`.
- **Output side**
  - Byte transfer occurs when `data_valid && byte_ready`.
  - While `byte_ready` is low, `data_out`, `data_last` and `data_tag` hold stable.
- **FSM**
  - `IDLE`: `data_valid` = 0. Moves to `STREAM` when `fifo_level != 0`, with byte counter = 0.
  - `STREAM`: presents byte[counter] of the head entry. Each transfer increments the counter. A transfer with counter = `TILE_BYTES-1` pops the head and resets the counter to 0.
    - If another tile remains after the pop, the FSM stays in `STREAM` and that tile's byte 0 appears on the next cycle, with no gap.
    - Otherwise the FSM returns to `IDLE`.
- **Counter width:** `$clog2(TILE_BYTES)` bits. It never exceeds `TILE_BYTES-1`.
- **Simultaneous push and pop** (not full): `fifo_level` is unchanged, and both pointers advance.
- **Reset** (including mid-tile): on the first edge with `rst_n` low:
  - the FIFO is flushed and the partial tile is dropped;
  - the FSM goes to `IDLE` and the counter to 0;
  - all outputs are 0, except `tile_ready`, which is 1.
  - While `rst_n` is low, `tile_valid` is ignored.

## Timing
- All outputs are registered, except `tile_ready` and `busy`, which are decoded from registered state.
- Reset values: `data_valid`, `data_last` = 0; `data_out` = 0x00; `data_tag` = 0; `fifo_level` = 0; `busy` = 0; `expected_crc` = 0x0000; `expected_crc_valid` = 0; `tile_ready` = 1.
- Latency: a tile pushed at edge N into an idle, empty block gives `data_valid` high after edge N+1.
- With `byte_ready` held high, byte k appears in cycle N+1+k and `data_last` in cycle N+`TILE_BYTES`.
- Sustained throughput is 1 byte/cycle. A full tile takes `TILE_BYTES` cycles.
- `expected_crc_valid` pulses in the cycle after the last-byte transfer. This matches the hash generator's `hash_valid` timing.

## Configuration
- **Macro:** `TILE_STREAM_CRC_EN`.
- **When defined:**
  - A running CRC-16-CCITT is maintained: polynomial 0x1021, initial value 0xFFFF, no reflection, no final XOR.
  - The CRC updates on every byte transfer, MSB first.
  - On the last-byte transfer, the final value is registered to `expected_crc` and `expected_crc_valid` pulses for one cycle.
  - The CRC reinitializes to 0xFFFF for the next tile, and also on reset.
- **When undefined:** no CRC logic is built; `expected_crc` is tied to 0x0000 and `expected_crc_valid` to 0. The ports are present in both builds.

## Test plan
- **Single tile, `byte_ready` = 1:** push a tile with bytes 0x00..0x0F and tag 0x5A → 16 consecutive bytes 0x00..0x0F; `data_last` only on 0x0F; `data_tag` = 0x5A throughout; `busy` falls after the last transfer.
- **Back-to-back:** push tiles A, B, C on consecutive cycles with `FIFO_DEPTH` = 2 → `tile_ready` drops on the third attempt; C is accepted once A pops; 48 bytes are emitted with no idle cycle between tiles.
- **Backpressure:** toggle `byte_ready` every cycle → each byte is held stable while stalled; tile completes in 32 cycles; no byte is lost or duplicated.
- **Mid-tile reset:** assert `rst_n` low during byte 7 of a tile with a second tile queued → the next cycle shows `data_valid` = 0 and `fifo_level` = 0; after release, the first push restarts at byte 0.
- **CRC check (`TILE_STREAM_CRC_EN`, `TILE_BYTES` = 9):** tile = ASCII "123456789" → `expected_crc` = 0x29B1 with a one-cycle `expected_crc_valid` after `data_last`; this must equal the hash generator's `hash_out` in the same cycle.
- **Macro off:** same stimulus → `expected_crc_valid` stays 0 and `expected_crc` = 0x0000.
